// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the key schedule and the decrypt datapath.
// State byte layout: row r, column c lives at index 15-(4r+c).
package aes_pkg;

  localparam int NR    = 10;
  localparam int RND_W = 4;
  localparam logic [RND_W-1:0] NR_IDX = RND_W'(NR);

  typedef logic [7:0]        byte_t;
  typedef logic [3:0][7:0]   word_t;   // [3] is row 0, matching FIPS word hex order
  typedef logic [15:0][7:0]  state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  localparam byte_t RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Most significant byte is S(0x00), so the entry for input b is SBOX[~b].
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic word_t get_col(input state_t s, input int c);
    return {s[15-c], s[11-c], s[7-c], s[3-c]};
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    word_t  a;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a = get_col(s, c);
      o[15-c] = gmul(a[3], 8'h0e) ^ gmul(a[2], 8'h0b) ^ gmul(a[1], 8'h0d) ^ gmul(a[0], 8'h09);
      o[11-c] = gmul(a[3], 8'h09) ^ gmul(a[2], 8'h0e) ^ gmul(a[1], 8'h0b) ^ gmul(a[0], 8'h0d);
      o[7-c]  = gmul(a[3], 8'h0d) ^ gmul(a[2], 8'h09) ^ gmul(a[1], 8'h0e) ^ gmul(a[0], 8'h0b);
      o[3-c]  = gmul(a[3], 8'h0b) ^ gmul(a[2], 8'h0d) ^ gmul(a[1], 8'h09) ^ gmul(a[0], 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, purely combinational table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = SBOX[~byte_i];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion, one round key per clock into an 11-entry buffer read by round.
// Define AES_KEY_INVMIX_EN to return InvMixColumns'd keys for rounds 1..NR-1 (equivalent inverse cipher).
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0][7:0]  key,
  output logic              busy,
  output logic              ready,
  input  logic [RND_W-1:0]  rd_round,
  output logic [15:0][7:0]  rd_key
);

  ks_state_e         state_q, state_d;
  logic [RND_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  state_t            rk_q [NR+1];

  logic              wr_en;
  logic [RND_W-1:0]  wr_idx;
  state_t            wr_data;

  state_t            prev_key;
  state_t            next_key;
  word_t             w3;
  word_t             rot_w;
  word_t             sub_w;
  byte_t             rcon_b;
  word_t             col_acc;

  assign prev_key = (cnt_q != '0 && cnt_q <= NR_IDX) ? rk_q[cnt_q - 1'b1] : '0;
  assign rcon_b   = (cnt_q != '0 && cnt_q <= NR_IDX) ? RCON[cnt_q] : 8'h00;
  assign w3       = get_col(prev_key, 3);
  assign rot_w    = {w3[2:0], w3[3]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .byte_i (rot_w[gi]),
        .byte_o (sub_w[gi])
      );
    end
  endgenerate

  // Each new column chains from the one just produced in the same round.
  always_comb begin
    next_key = '0;
    col_acc  = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) col_acc = get_col(prev_key, 0) ^ sub_w ^ {rcon_b, 24'h0};
      else        col_acc = get_col(prev_key, c) ^ col_acc;
      next_key[15-c] = col_acc[3];
      next_key[11-c] = col_acc[2];
      next_key[7-c]  = col_acc[1];
      next_key[3-c]  = col_acc[0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_data = next_key;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          wr_data = key;
          cnt_d   = RND_W'(1);
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        if (cnt_q == NR_IDX) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else if (wr_en && wr_idx <= NR_IDX) begin
      rk_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_round <= NR_IDX) begin
      rd_key = rk_q[rd_round];
`ifdef AES_KEY_INVMIX_EN
      if (rd_round != '0 && rd_round != NR_IDX) rd_key = inv_mix_columns(rk_q[rd_round]);
`else
`endif
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed self-checking bench for aes_key_schedule using FIPS-197 A.1 and all-zero key vectors.
module tb_aes_key_schedule;
  import aes_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0][7:0]  key;
  logic              busy;
  logic              ready;
  logic [RND_W-1:0]  rd_round;
  logic [15:0][7:0]  rd_key;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1     = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R2     = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R9     = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] R10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1     = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z2     = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_schedule dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .ready    (ready),
    .rd_round (rd_round),
    .rd_key   (rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // FIPS byte stream k[4c+r] -> row-major index 15-(4r+c)
  function automatic logic [127:0] f2s(input logic [127:0] f);
    logic [127:0] s;
    s = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[8*(15-(4*r+c)) +: 8] = f[8*(15-(4*c+r)) +: 8];
    return s;
  endfunction

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h1b) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Reference InvMixColumns on a FIPS-ordered block (one 32-bit word per column)
  function automatic logic [127:0] ref_invmix_fips(input logic [127:0] f);
    logic [127:0] o;
    logic [7:0] b0, b1, b2, b3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = f[127-32*c -: 8];
      b1 = f[119-32*c -: 8];
      b2 = f[111-32*c -: 8];
      b3 = f[103-32*c -: 8];
      o[127-32*c -: 8] = ref_mul(8'h0e, b0) ^ ref_mul(8'h0b, b1) ^ ref_mul(8'h0d, b2) ^ ref_mul(8'h09, b3);
      o[119-32*c -: 8] = ref_mul(8'h09, b0) ^ ref_mul(8'h0e, b1) ^ ref_mul(8'h0b, b2) ^ ref_mul(8'h0d, b3);
      o[111-32*c -: 8] = ref_mul(8'h0d, b0) ^ ref_mul(8'h09, b1) ^ ref_mul(8'h0e, b2) ^ ref_mul(8'h0b, b3);
      o[103-32*c -: 8] = ref_mul(8'h0b, b0) ^ ref_mul(8'h0d, b1) ^ ref_mul(8'h09, b2) ^ ref_mul(8'h0e, b3);
    end
    return o;
  endfunction

  // Expected rd_key (index layout) for a raw FIPS round key at round r
  function automatic logic [127:0] exp_rd(input logic [127:0] fips, input int r);
`ifdef AES_KEY_INVMIX_EN
    if (r >= 1 && r <= NR - 1) return f2s(ref_invmix_fips(fips));
`else
`endif
    return f2s(fips);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ready(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (!ready && n < 40) begin
      step();
      n++;
      if (!ready && busy) busy_cnt++;
    end
  endtask

  task automatic read_rk(input int r);
    rd_round = RND_W'(r);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; key = '0; rd_round = '0;
    step(); step();
    reset = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    read_rk(0);
    total++; if (rd_key !== 128'h0) begin bad++; $display("FAIL reset_rk0 got=%h exp=0", rd_key); end
    read_rk(10);
    total++; if (rd_key !== 128'h0) begin bad++; $display("FAIL reset_rk10 got=%h exp=0", rd_key); end
    $display("test_reset: busy=%b ready=%b", busy, ready);
  endtask

  task automatic test_fips();
    int n, bc;
    int rs [5];
    logic [127:0] ex [5];
    rs = '{0, 1, 2, 9, 10};
    ex = '{K_FIPS, R1, R2, R9, R10};
    pulse_start(f2s(K_FIPS));
    total++; if (busy !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL fips_start busy/ready got=%b%b exp=10", busy, ready); end
    wait_ready(n, bc);
    total++; if (n !== 10) begin bad++; $display("FAIL fips_latency got=%0d exp=10", n); end
    total++; if (bc !== 9) begin bad++; $display("FAIL fips_busy_cycles got=%0d exp=9", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fips_busy_done got=%b exp=0", busy); end
    for (int i = 0; i < 5; i++) begin
      read_rk(rs[i]);
      total++;
      if (rd_key !== exp_rd(ex[i], rs[i])) begin
        bad++; $display("FAIL fips_round%0d got=%h exp=%h", rs[i], rd_key, exp_rd(ex[i], rs[i]));
      end
    end
    read_rk(10);
    total++; if ({rd_key[15], rd_key[14], rd_key[13], rd_key[12]} !== 32'hd0c9e1b6) begin
      bad++; $display("FAIL fips_r10_row0 got=%h exp=d0c9e1b6", {rd_key[15], rd_key[14], rd_key[13], rd_key[12]});
    end
    $display("test_fips: latency=%0d round10=%h", n, rd_key);
  endtask

  task automatic test_restart_zero();
    int n, bc;
    pulse_start(128'h0);
    total++; if (ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL restart_flags ready/busy got=%b%b exp=01", ready, busy); end
    read_rk(0);
    total++; if (rd_key !== 128'h0) begin bad++; $display("FAIL restart_rk0 got=%h exp=0", rd_key); end
    read_rk(10);
    total++; if (rd_key !== f2s(R10)) begin bad++; $display("FAIL restart_old_rk10 got=%h exp=%h", rd_key, f2s(R10)); end
    wait_ready(n, bc);
    total++; if (n !== 10) begin bad++; $display("FAIL zero_latency got=%0d exp=10", n); end
    read_rk(1);
    total++; if (rd_key !== exp_rd(Z1, 1)) begin bad++; $display("FAIL zero_round1 got=%h exp=%h", rd_key, exp_rd(Z1, 1)); end
    read_rk(2);
    total++; if (rd_key !== exp_rd(Z2, 2)) begin bad++; $display("FAIL zero_round2 got=%h exp=%h", rd_key, exp_rd(Z2, 2)); end
    read_rk(10);
    total++; if (rd_key !== f2s(Z10)) begin bad++; $display("FAIL zero_round10 got=%h exp=%h", rd_key, f2s(Z10)); end
    for (int r = 11; r <= 15; r++) begin
      read_rk(r);
      total++; if (rd_key !== 128'h0) begin bad++; $display("FAIL oob_round%0d got=%h exp=0", r, rd_key); end
    end
    $display("test_restart_zero: latency=%0d round1=%h", n, exp_rd(Z1, 1));
  endtask

  task automatic test_ignore_start();
    int n, bc;
    pulse_start(f2s(K_FIPS));
    step(); step(); step();
    key   = {16{8'hff}};
    start = 1'b1;
    step();
    start = 1'b0;
    wait_ready(n, bc);
    total++; if (n !== 6) begin bad++; $display("FAIL ignore_latency got=%0d exp=6", n); end
    read_rk(0);
    total++; if (rd_key !== f2s(K_FIPS)) begin bad++; $display("FAIL ignore_rk0 got=%h exp=%h", rd_key, f2s(K_FIPS)); end
    read_rk(10);
    total++; if (rd_key !== f2s(R10)) begin bad++; $display("FAIL ignore_rk10 got=%h exp=%h", rd_key, f2s(R10)); end
    $display("test_ignore_start: ready after %0d more edges", n);
  endtask

  task automatic test_reset_mid();
    int n, bc;
    pulse_start(f2s(K_FIPS));
    step(); step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL midreset_flags busy/ready got=%b%b exp=00", busy, ready); end
    read_rk(0);
    total++; if (rd_key !== 128'h0) begin bad++; $display("FAIL midreset_rk0 got=%h exp=0", rd_key); end
    reset = 1'b0;
    step();
    total++; if (busy !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL midreset_idle busy/ready got=%b%b exp=00", busy, ready); end
    pulse_start(f2s(K_FIPS));
    wait_ready(n, bc);
    total++; if (n !== 10) begin bad++; $display("FAIL midreset_latency got=%0d exp=10", n); end
    read_rk(1);
    total++; if (rd_key !== exp_rd(R1, 1)) begin bad++; $display("FAIL midreset_round1 got=%h exp=%h", rd_key, exp_rd(R1, 1)); end
    $display("test_reset_mid: recovered latency=%0d", n);
  endtask

`ifdef AES_KEY_INVMIX_EN
  task automatic test_invmix();
    read_rk(0);
    total++; if (rd_key !== f2s(K_FIPS)) begin bad++; $display("FAIL invmix_rk0 got=%h exp=%h", rd_key, f2s(K_FIPS)); end
    read_rk(10);
    total++; if (rd_key !== f2s(R10)) begin bad++; $display("FAIL invmix_rk10 got=%h exp=%h", rd_key, f2s(R10)); end
    read_rk(1);
    total++; if (rd_key !== f2s(ref_invmix_fips(R1))) begin bad++; $display("FAIL invmix_rk1 got=%h exp=%h", rd_key, f2s(ref_invmix_fips(R1))); end
    $display("test_invmix: round1=%h", rd_key);
  endtask
`else
`endif

  initial begin
    test_reset();
    test_fips();
    test_restart_zero();
    test_ignore_start();
    test_reset_mid();
`ifdef AES_KEY_INVMIX_EN
    test_invmix();
`else
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
